clock_gate_sequencer: RTL and testbench

Sequences the enable handshakes of up to `NUM_DOMAINS` clock-route gates, each being a gate/control pair with a 4-phase `async_enable`/`async_enable_ack` interface. It turns them on in ascending index order and off in descending order, one domain at a time. Each completed handshake is followed by a programmable settle interval, and a handshake that does not complete in time traps in a sticky error state. It sits in the always-on clock/power management logic between the power-mode controller (`req_on`) and the gate macros.

---
 rtl/clock_gate_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_clock_gate_sequencer.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_gate_sequencer.sv
// Ordered on/off sequencing of clock-route gates through 4-phase
// enable/ack handshakes, with settle delay and sticky timeout trap.
module clock_gate_sequencer #(
    parameter int NUM_DOMAINS    = 4,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req_on,
    input  logic [NUM_DOMAINS-1:0] domain_mask,
    output logic [NUM_DOMAINS-1:0] async_enable,
    input  logic [NUM_DOMAINS-1:0] async_enable_ack,
    output logic                   busy,
    output logic                   all_on,
    output logic                   all_off,
    output logic                   error,
    output logic [3:0]             error_domain
);

    localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_OFF,
        S_UP_REQ,
        S_UP_SETTLE,
        S_ON,
        S_DN_REQ,
        S_DN_SETTLE,
        S_ERROR
    } state_t;

    state_t                   state;
    logic [3:0]               idx;
    logic [NUM_DOMAINS-1:0]   mask_q;
    logic [15:0]              cnt;
    logic [NUM_DOMAINS-1:0]   ack_meta;
    logic [NUM_DOMAINS-1:0]   ack_sync;

    logic [3:0] lo_idx;
    logic [3:0] hi_idx;
    logic [3:0] up_idx;
    logic [3:0] dn_idx;
    logic       up_found;
    logic       dn_found;
    logic       ack_cur;

    function automatic logic [NUM_DOMAINS-1:0] onehot(input logic [3:0] v);
        onehot = '0;
        for (int i = 0; i < NUM_DOMAINS; i++)
            if (int'(v) == i) onehot[i] = 1'b1;
    endfunction

    // Priority searches: lowest requested, highest enabled, and
    // nearest latched neighbour above/below the current index.
    always_comb begin
        lo_idx   = '0;
        hi_idx   = '0;
        up_idx   = idx;
        dn_idx   = idx;
        up_found = 1'b0;
        dn_found = 1'b0;
        for (int i = NUM_DOMAINS - 1; i >= 0; i--) begin
            if (domain_mask[i]) lo_idx = 4'(i);
            if (mask_q[i] && i > int'(idx)) begin
                up_found = 1'b1;
                up_idx   = 4'(i);
            end
        end
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            if (async_enable[i]) hi_idx = 4'(i);
            if (mask_q[i] && i < int'(idx)) begin
                dn_found = 1'b1;
                dn_idx   = 4'(i);
            end
        end
    end

    assign ack_cur = |(ack_sync & onehot(idx));

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_OFF;
            idx          <= '0;
            mask_q       <= '0;
            cnt          <= '0;
            async_enable <= '0;
            error_domain <= '0;
            ack_meta     <= '0;
            ack_sync     <= '0;
        end else begin
            ack_meta <= async_enable_ack;
            ack_sync <= ack_meta;
            unique case (state)
                S_OFF: begin
                    if (req_on) begin
                        mask_q <= domain_mask;
                        cnt    <= '0;
                        if (domain_mask == '0) begin
                            state <= S_ON;
                        end else begin
                            idx          <= lo_idx;
                            async_enable <= async_enable | onehot(lo_idx);
                            state        <= S_UP_REQ;
                        end
                    end
                end
                S_UP_REQ: begin
                    if (ack_cur) begin
                        cnt   <= '0;
                        state <= S_UP_SETTLE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        error_domain <= idx;
                        state        <= S_ERROR;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_UP_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt <= '0;
                        if (!req_on) begin
                            async_enable <= async_enable & ~onehot(idx);
                            state        <= S_DN_REQ;
                        end else if (up_found) begin
                            idx          <= up_idx;
                            async_enable <= async_enable | onehot(up_idx);
                            state        <= S_UP_REQ;
                        end else begin
                            state <= S_ON;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_ON: begin
                    // Power-down walks whatever is actually on, mask or not.
                    if (!req_on) begin
                        mask_q <= async_enable;
                        cnt    <= '0;
                        if (async_enable == '0) begin
                            state <= S_OFF;
                        end else begin
                            idx          <= hi_idx;
                            async_enable <= async_enable & ~onehot(hi_idx);
                            state        <= S_DN_REQ;
                        end
                    end
                end
                S_DN_REQ: begin
                    if (!ack_cur) begin
                        cnt   <= '0;
                        state <= S_DN_SETTLE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        error_domain <= idx;
                        state        <= S_ERROR;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_DN_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt <= '0;
                        if (req_on) begin
                            async_enable <= async_enable | onehot(idx);
                            state        <= S_UP_REQ;
                        end else if (dn_found) begin
                            idx          <= dn_idx;
                            async_enable <= async_enable & ~onehot(dn_idx);
                            state        <= S_DN_REQ;
                        end else begin
                            state <= S_OFF;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_ERROR: begin
                    state <= S_ERROR;
                end
                default: begin
                    state <= S_ERROR;
                end
            endcase
        end
    end

    assign all_off = (state == S_OFF);
    assign all_on  = (state == S_ON);
    assign error   = (state == S_ERROR);
    assign busy    = !(all_off || all_on || error);

endmodule

// File: tb/tb_clock_gate_sequencer.sv
// Bench for clock_gate_sequencer: gate model with programmable ack
// delay, event-list reference model, directed and random scenarios.
module tb_clock_gate_sequencer;

    localparam int N       = 4;
    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 64;

    logic         clock = 1'b0;
    logic         reset;
    logic         req_on;
    logic [N-1:0] domain_mask;
    logic [N-1:0] async_enable;
    logic [N-1:0] async_enable_ack = '0;
    logic         busy;
    logic         all_on;
    logic         all_off;
    logic         error;
    logic [3:0]   error_domain;

    clock_gate_sequencer #(
        .NUM_DOMAINS   (N),
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .req_on          (req_on),
        .domain_mask     (domain_mask),
        .async_enable    (async_enable),
        .async_enable_ack(async_enable_ack),
        .busy            (busy),
        .all_on          (all_on),
        .all_off         (all_off),
        .error           (error),
        .error_domain    (error_domain)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int gate_dly    = 3;
    logic [N-1:0] dead = '0;
    bit scramble = 1'b0;
    int gcnt [N] = '{default: 0};

    always @(posedge clock) cyc <= cyc + 1;

    // Gate model: ack follows enable gate_dly cycles later unless dead.
    always @(posedge clock) begin
        for (int i = 0; i < N; i++) begin
            if (async_enable[i] != async_enable_ack[i] && !dead[i]) begin
                if (gcnt[i] + 1 >= gate_dly) begin
                    async_enable_ack[i] <= async_enable[i];
                    gcnt[i] <= 0;
                end else begin
                    gcnt[i] <= gcnt[i] + 1;
                end
            end else begin
                gcnt[i] <= 0;
            end
        end
    end

    typedef struct {
        int   t;
        int   d;
        logic v;
    } ev_t;

    ev_t got_q[$];
    ev_t exp_q[$];
    logic [N-1:0] prev_en = '0;
    logic [N-1:0] ever_on = '0;

    always @(negedge clock) begin
        if (!$isunknown(async_enable)) begin
            for (int i = 0; i < N; i++)
                if (async_enable[i] !== prev_en[i])
                    got_q.push_back('{cyc, i, async_enable[i]});
            prev_en = async_enable;
            ever_on = ever_on | async_enable;
        end
    end

    function automatic string got_str();
        string s = "";
        foreach (got_q[i])
            s = {s, $sformatf("%0d:%0d%s ", got_q[i].t, got_q[i].d,
                              got_q[i].v ? "+" : "-")};
        return s;
    endfunction

    function automatic string exp_str();
        string s = "";
        foreach (exp_q[i])
            s = {s, $sformatf("%0d:%0d%s ", exp_q[i].t, exp_q[i].d,
                              exp_q[i].v ? "+" : "-")};
        return s;
    endfunction

    // Ascending walk: j-th requested domain rises j*sp after start.
    function automatic void model_up(input logic [N-1:0] m, input int k,
                                     input int sp, output int done);
        int j = 0;
        for (int i = 0; i < N; i++)
            if (m[i]) begin
                exp_q.push_back('{k + sp * j, i, 1'b1});
                j++;
            end
        done = k + sp * j;
    endfunction

    function automatic void model_dn(input logic [N-1:0] e, input int k,
                                     input int sp, output int done);
        int j = 0;
        for (int i = N - 1; i >= 0; i--)
            if (e[i]) begin
                exp_q.push_back('{k + sp * j, i, 1'b0});
                j++;
            end
        done = k + sp * j;
    endfunction

    task automatic wait_for(input int which, input int budget,
                            output int stamp, output bit ok);
        ok    = 1'b0;
        stamp = -1;
        for (int n = 0; n < budget; n++) begin
            @(negedge clock);
            if (scramble) domain_mask = 4'($urandom);
            if ((which == 0 && all_on === 1'b1) ||
                (which == 1 && all_off === 1'b1) ||
                (which == 2 && error === 1'b1)) begin
                ok    = 1'b1;
                stamp = cyc;
                break;
            end
        end
    endtask

    task automatic start_req(input logic r, input logic [N-1:0] m,
                             output int k);
        @(negedge clock);
        got_q.delete();
        exp_q.delete();
        req_on      = r;
        domain_mask = m;
        k           = cyc + 1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req_on = 1'b0;
        domain_mask = '0;
        repeat (3) @(negedge clock);
        if (async_enable !== 4'b0000) begin
            $display("FAIL reset_en: got %b want 0000", async_enable);
            miscompares++;
        end
        vectors++;
        if (all_off !== 1'b1 || all_on !== 1'b0) begin
            $display("FAIL reset_flags: all_off=%b all_on=%b want 1,0",
                     all_off, all_on);
            miscompares++;
        end
        vectors++;
        if (busy !== 1'b0 || error !== 1'b0) begin
            $display("FAIL reset_busy_err: busy=%b error=%b want 0,0",
                     busy, error);
            miscompares++;
        end
        vectors++;
        if (error_domain !== 4'd0) begin
            $display("FAIL reset_errdom: got %0d want 0", error_domain);
            miscompares++;
        end
        vectors++;
        reset = 1'b0;
    endtask

    task automatic test_power_up;
        int k, done, st;
        bit ok;
        gate_dly = 3;
        start_req(1'b1, 4'b1111, k);
        model_up(4'b1111, k, 10, done);
        @(negedge clock);
        if (busy !== 1'b1 || async_enable !== 4'b0001) begin
            $display("FAIL pu_first: busy=%b en=%b want 1,0001",
                     busy, async_enable);
            miscompares++;
        end
        vectors++;
        wait_for(0, 100, st, ok);
        if (!ok || st !== done) begin
            $display("FAIL pu_all_on: got cycle %0d want %0d", st, done);
            miscompares++;
        end
        vectors++;
        if (got_str() != exp_str()) begin
            $display("FAIL pu_events: got %s want %s", got_str(), exp_str());
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_power_down;
        int k, done, st;
        bit ok;
        start_req(1'b0, 4'b0000, k);
        model_dn(4'b1111, k, 10, done);
        wait_for(1, 100, st, ok);
        if (!ok || st !== done) begin
            $display("FAIL pd_all_off: got cycle %0d want %0d", st, done);
            miscompares++;
        end
        vectors++;
        if (got_str() != exp_str()) begin
            $display("FAIL pd_events: got %s want %s", got_str(), exp_str());
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_masked_down;
        int k, done, st;
        bit ok;
        ever_on = '0;
        start_req(1'b1, 4'b1010, k);
        model_up(4'b1010, k, 10, done);
        wait_for(0, 100, st, ok);
        if (!ok || st !== done || async_enable !== 4'b1010) begin
            $display("FAIL md_up: cycle %0d en=%b want %0d 1010",
                     st, async_enable, done);
            miscompares++;
        end
        vectors++;
        start_req(1'b0, 4'b1111, k);
        model_dn(4'b1010, k, 10, done);
        wait_for(1, 100, st, ok);
        if (!ok || st !== done) begin
            $display("FAIL md_all_off: got cycle %0d want %0d", st, done);
            miscompares++;
        end
        vectors++;
        if (got_str() != exp_str()) begin
            $display("FAIL md_events: got %s want %s", got_str(), exp_str());
            miscompares++;
        end
        vectors++;
        if ((ever_on & 4'b0101) !== 4'b0000) begin
            $display("FAIL md_masked: ever on %b want 0,2 never", ever_on);
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_reversal;
        int k, done, st, e1;
        bit ok;
        start_req(1'b1, 4'b1111, k);
        e1 = -1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clock);
            if (async_enable[1] === 1'b1) begin
                e1 = cyc;
                req_on = 1'b0;
                break;
            end
        end
        if (e1 !== k + 10) begin
            $display("FAIL rv_en1: got cycle %0d want %0d", e1, k + 10);
            miscompares++;
        end
        vectors++;
        exp_q.push_back('{k, 0, 1'b1});
        exp_q.push_back('{k + 10, 1, 1'b1});
        exp_q.push_back('{e1 + 10, 1, 1'b0});
        exp_q.push_back('{e1 + 20, 0, 1'b0});
        wait_for(1, 100, st, ok);
        if (!ok || st !== e1 + 30) begin
            $display("FAIL rv_all_off: got cycle %0d want %0d", st, e1 + 30);
            miscompares++;
        end
        vectors++;
        if (got_str() != exp_str()) begin
            $display("FAIL rv_events: got %s want %s", got_str(), exp_str());
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_timeout;
        int k, st;
        bit ok;
        dead = 4'b0100;
        start_req(1'b1, 4'b1111, k);
        exp_q.push_back('{k, 0, 1'b1});
        exp_q.push_back('{k + 10, 1, 1'b1});
        exp_q.push_back('{k + 20, 2, 1'b1});
        wait_for(2, 200, st, ok);
        if (!ok || st !== k + 20 + TIMEOUT) begin
            $display("FAIL to_time: got cycle %0d want %0d",
                     st, k + 20 + TIMEOUT);
            miscompares++;
        end
        vectors++;
        if (error_domain !== 4'd2 || async_enable !== 4'b0111) begin
            $display("FAIL to_state: dom=%0d en=%b want 2 0111",
                     error_domain, async_enable);
            miscompares++;
        end
        vectors++;
        if (busy !== 1'b0 || all_on !== 1'b0 || all_off !== 1'b0) begin
            $display("FAIL to_flags: busy=%b on=%b off=%b want 0,0,0",
                     busy, all_on, all_off);
            miscompares++;
        end
        vectors++;
        req_on = 1'b0;
        repeat (8) @(negedge clock);
        domain_mask = 4'b0000;
        req_on = 1'b1;
        repeat (8) @(negedge clock);
        if (error !== 1'b1 || async_enable !== 4'b0111) begin
            $display("FAIL to_sticky: err=%b en=%b want 1 0111",
                     error, async_enable);
            miscompares++;
        end
        vectors++;
        if (got_str() != exp_str()) begin
            $display("FAIL to_events: got %s want %s", got_str(), exp_str());
            miscompares++;
        end
        vectors++;
        req_on = 1'b0;
        reset = 1'b1;
        repeat (6) @(negedge clock);
        reset = 1'b0;
        dead = '0;
        if (all_off !== 1'b1 || error !== 1'b0 || async_enable !== 4'b0000) begin
            $display("FAIL to_reset: off=%b err=%b en=%b want 1,0,0000",
                     all_off, error, async_enable);
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_empty_mask;
        int k, st;
        bit ok;
        start_req(1'b1, 4'b0000, k);
        wait_for(0, 10, st, ok);
        if (!ok || st !== k) begin
            $display("FAIL em_on: got cycle %0d want %0d", st, k);
            miscompares++;
        end
        vectors++;
        start_req(1'b0, 4'b0000, k);
        wait_for(1, 10, st, ok);
        if (!ok || st !== k || got_q.size() !== 0) begin
            $display("FAIL em_off: cycle %0d events %0d want %0d 0",
                     st, got_q.size(), k);
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_random;
        int k, done, st, sp;
        bit ok;
        logic [N-1:0] m;
        for (int it = 0; it < 8; it++) begin
            m = 4'($urandom_range(0, 15));
            gate_dly = $urandom_range(1, 5);
            sp = gate_dly + 3 + SETTLE;
            start_req(1'b1, m, k);
            model_up(m, k, sp, done);
            scramble = 1'b1;
            wait_for(0, sp * N + 20, st, ok);
            if (!ok || st !== done || async_enable !== m) begin
                $display("FAIL rnd_up%0d: cycle %0d en=%b want %0d %b",
                         it, st, async_enable, done, m);
                miscompares++;
            end
            vectors++;
            if (got_str() != exp_str()) begin
                $display("FAIL rnd_up_ev%0d: got %s want %s",
                         it, got_str(), exp_str());
                miscompares++;
            end
            vectors++;
            start_req(1'b0, 4'($urandom), k);
            model_dn(m, k, sp, done);
            wait_for(1, sp * N + 20, st, ok);
            scramble = 1'b0;
            if (!ok || st !== done) begin
                $display("FAIL rnd_dn%0d: got cycle %0d want %0d",
                         it, st, done);
                miscompares++;
            end
            vectors++;
            if (got_str() != exp_str()) begin
                $display("FAIL rnd_dn_ev%0d: got %s want %s",
                         it, got_str(), exp_str());
                miscompares++;
            end
            vectors++;
        end
    endtask

    initial begin
        reset       = 1'b1;
        req_on      = 1'b0;
        domain_mask = '0;
        test_reset;
        test_power_up;
        test_power_down;
        test_masked_down;
        test_reversal;
        test_timeout;
        test_empty_mask;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
